// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared types and defaults for the elevator car/door controller.
//   ctrl_state_t : controller state (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN)
//   DIR_UP/DIR_DOWN : encoding of the direction memory bit
//   *_DEF : default geometry and timing parameters
// -----------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } ctrl_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned FLOORS_DEF        = 8;
  localparam int unsigned TRAVEL_CYCLES_DEF = 16;
  localparam int unsigned DOOR_CYCLES_DEF   = 32;

endpackage

// File: rtl/elevator_ctrl_if.sv
// -----------------------------------------------------------------------------
// elevator_ctrl_if
// Request/clear bus between the button-latch stage (master) and the car
// controller (slave).
//   active_in_levels        : car calls, one bit per floor
//   active_out_up_levels    : hall up calls, floors 0..FLOORS-2
//   active_out_down_levels  : hall down calls, floors 1..FLOORS-1 (bit f-1)
//   inactivate_*            : one-cycle clear pulses back to the button stage
// -----------------------------------------------------------------------------
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS = FLOORS_DEF
);

  logic [FLOORS-1:0] active_in_levels;
  logic [FLOORS-2:0] active_out_up_levels;
  logic [FLOORS-2:0] active_out_down_levels;

  logic [FLOORS-1:0] inactivate_in_levels;
  logic [FLOORS-2:0] inactivate_out_up_levels;
  logic [FLOORS-2:0] inactivate_out_down_levels;

  modport master (
    output active_in_levels,
    output active_out_up_levels,
    output active_out_down_levels,
    input  inactivate_in_levels,
    input  inactivate_out_up_levels,
    input  inactivate_out_down_levels
  );

  modport slave (
    input  active_in_levels,
    input  active_out_up_levels,
    input  active_out_down_levels,
    output inactivate_in_levels,
    output inactivate_out_up_levels,
    output inactivate_out_down_levels
  );

endinterface

// File: rtl/elevator_timer.sv
// -----------------------------------------------------------------------------
// elevator_timer
// Loadable down-counter that saturates at zero.
//   clk      : clock, rising edge
//   reset    : synchronous, active-low; clears the count
//   load     : load load_val this cycle (priority over counting)
//   load_val : value to load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module elevator_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_ctrl
// SCAN car motion and door controller. Consumes latched requests, moves the
// car one floor per TRAVEL_CYCLES, holds the door open DOOR_CYCLES and returns
// one-cycle clear pulses for served calls.
//   clk         : clock, rising edge
//   reset       : synchronous, active-low
//   req_if      : request/clear bus (slave side)
//   door_hold   : (only with ELEVATOR_CTRL_DOOR_HOLD_EN) keeps the door open
//   floor       : current car floor
//   motor_up    : high for every MOVE_UP cycle
//   motor_down  : high for every MOVE_DOWN cycle
//   door_open   : high for every DOOR_OPEN cycle
//   dir_up      : direction memory (1 = up, 0 = down)
// Optional feature macro: ELEVATOR_CTRL_DOOR_HOLD_EN
// -----------------------------------------------------------------------------
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS        = FLOORS_DEF,
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int unsigned DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  elevator_ctrl_if.slave            req_if,
`ifdef ELEVATOR_CTRL_DOOR_HOLD_EN
  input  logic                      door_hold,
`endif
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      motor_up,
  output logic                      motor_down,
  output logic                      door_open,
  output logic                      dir_up
);

  localparam int unsigned FW = $clog2(FLOORS);
  localparam int unsigned HW = FLOORS - 1;
  localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
  localparam int unsigned DW = $clog2(DOOR_CYCLES);

  ctrl_state_t       state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d, nf;
  logic              dir_up_q, dir_d;
  logic              motor_up_q, motor_down_q, door_open_q;
  logic [FLOORS-1:0] in_clr_q, in_clr_d;
  logic [HW-1:0]     up_clr_q, up_clr_d;
  logic [HW-1:0]     dn_clr_q, dn_clr_d;

  logic [FLOORS-1:0] in_v, up_v, dn_v, req_v;
  logic              above_q, below_q;
  logic              travel_load, travel_zero;
  logic              door_load, door_zero;
  logic              hold;
  logic              do_eval, enter_door;
  logic              beyond, opp, svc_up;

  function automatic logic any_above(input logic [FLOORS-1:0] v,
                                     input logic [FW-1:0]     f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (FW'(i) > f && v[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v,
                                     input logic [FW-1:0]     f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (FW'(i) < f && v[i]) r = 1'b1;
    end
    return r;
  endfunction

`ifdef ELEVATOR_CTRL_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Hall vectors widened to one bit per floor; the missing terminal bits are 0.
  assign in_v    = req_if.active_in_levels;
  assign up_v    = {1'b0, req_if.active_out_up_levels};
  assign dn_v    = {req_if.active_out_down_levels, 1'b0};
  assign req_v   = in_v | up_v | dn_v;
  assign above_q = any_above(req_v, floor_q);
  assign below_q = any_below(req_v, floor_q);

  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_d       = dir_up_q;
    nf          = floor_q;
    do_eval     = 1'b0;
    enter_door  = 1'b0;
    travel_load = 1'b0;
    door_load   = 1'b0;
    in_clr_d    = '0;
    up_clr_d    = '0;
    dn_clr_d    = '0;
    beyond      = 1'b0;
    opp         = 1'b0;
    svc_up      = dir_up_q;

    unique case (state_q)
      IDLE: do_eval = 1'b1;
      MOVE_UP: begin
        if (travel_zero) begin
          nf      = floor_q + FW'(1);
          floor_d = nf;
          // Nothing left above also covers opposite calls here and calls
          // cancelled during travel.
          if (in_v[nf] || up_v[nf] || !any_above(req_v, nf) ||
              nf == FW'(FLOORS - 1)) begin
            if (req_v[nf]) enter_door = 1'b1;
            else           state_d    = IDLE;
          end else begin
            travel_load = 1'b1;
          end
        end
      end
      MOVE_DOWN: begin
        if (travel_zero) begin
          nf      = floor_q - FW'(1);
          floor_d = nf;
          if (in_v[nf] || dn_v[nf] || !any_below(req_v, nf) ||
              nf == '0) begin
            if (req_v[nf]) enter_door = 1'b1;
            else           state_d    = IDLE;
          end else begin
            travel_load = 1'b1;
          end
        end
      end
      DOOR_OPEN: begin
        if (hold)           door_load = 1'b1;
        else if (door_zero) do_eval   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Shared by IDLE and door expiry: the current direction gets first pick.
    if (do_eval) begin
      state_d = IDLE;
      if (req_v[floor_q]) begin
        enter_door = 1'b1;
      end else if (above_q && (dir_up_q || !below_q)) begin
        state_d     = MOVE_UP;
        dir_d       = DIR_UP;
        travel_load = 1'b1;
      end else if (below_q) begin
        state_d     = MOVE_DOWN;
        dir_d       = DIR_DOWN;
        travel_load = 1'b1;
      end
    end

    // Door entry fixes the service direction and clears only calls that are
    // actually latched, so no clear pulse ever targets an idle button.
    if (enter_door) begin
      state_d   = DOOR_OPEN;
      door_load = 1'b1;
      beyond    = dir_up_q ? any_above(req_v, floor_d) : any_below(req_v, floor_d);
      opp       = dir_up_q ? dn_v[floor_d] : up_v[floor_d];
      svc_up    = (!beyond && opp) ? ~dir_up_q : dir_up_q;
      dir_d     = svc_up;
      in_clr_d  = (FLOORS'(1) << floor_d) & in_v;
      if (svc_up) begin
        up_clr_d = (HW'(1) << floor_d) & req_if.active_out_up_levels;
      end else if (floor_d != '0) begin
        dn_clr_d = (HW'(1) << (floor_d - FW'(1))) & req_if.active_out_down_levels;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      dir_up_q     <= DIR_UP;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
      in_clr_q     <= '0;
      up_clr_q     <= '0;
      dn_clr_q     <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_d;
      motor_up_q   <= (state_d == MOVE_UP);
      motor_down_q <= (state_d == MOVE_DOWN);
      door_open_q  <= (state_d == DOOR_OPEN);
      in_clr_q     <= in_clr_d;
      up_clr_q     <= up_clr_d;
      dn_clr_q     <= dn_clr_d;
    end
  end

  elevator_timer #(
    .WIDTH (TW)
  ) u_travel_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (travel_load),
    .load_val (TW'(TRAVEL_CYCLES - 1)),
    .zero     (travel_zero)
  );

  elevator_timer #(
    .WIDTH (DW)
  ) u_door_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (door_load),
    .load_val (DW'(DOOR_CYCLES - 1)),
    .zero     (door_zero)
  );

  assign floor      = floor_q;
  assign motor_up   = motor_up_q;
  assign motor_down = motor_down_q;
  assign door_open  = door_open_q;
  assign dir_up     = dir_up_q;

  assign req_if.inactivate_in_levels       = in_clr_q;
  assign req_if.inactivate_out_up_levels   = up_clr_q;
  assign req_if.inactivate_out_down_levels = dn_clr_q;

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car motion and door controller for the elevator. It sits directly downstream of the button-latch stage and consumes its registered `active_in_levels`, `active_out_up_levels` and `active_out_down_levels` request vectors. It runs a direction-preserving (SCAN) state machine that moves the car, opens the door at served floors and returns one-cycle `inactivate_*` pulses to the button stage to clear the requests it has served.

## Interface
- `FLOORS`, 8: number of floors; floor index width `FW = $clog2(FLOORS)`.
- `TRAVEL_CYCLES`, 16: clock cycles to move one floor, ≥2.
- `DOOR_CYCLES`, 32: clock cycles the door stays open, ≥2.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `active_in_levels`  in  FLOORS  car calls.
- `active_out_up_levels`  in  FLOORS-1  hall up calls, floors 0..FLOORS-2.
- `active_out_down_levels`  in  FLOORS-1  hall down calls, floors 1..FLOORS-1.
- `inactivate_in_levels`  out  FLOORS  one-cycle clear pulse per floor.
- `inactivate_out_up_levels`  out  FLOORS-1  one-cycle clear pulse.
- `inactivate_out_down_levels`  out  FLOORS-1  one-cycle clear pulse.
- `floor`  out  FW  current car floor.
- `motor_up`, `motor_down`  out  1 each  drive commands; never both high.
- `door_open`  out  1  door open command.
- `dir_up`  out  1  direction memory: 1 = up, 0 = down.

## Operation
- Request vector `req[f]` = `active_in_levels[f]` | `up[f]` | `down[f]`. The missing hall bits (up at the top floor, down at floor 0) are treated as 0.
- `above` = any `req` strictly above `floor`. `below` = any `req` strictly below `floor`.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- **IDLE**
  - `req[floor]` → DOOR_OPEN.
  - Else, if `dir_up`: `above` → MOVE_UP; else `below` → MOVE_DOWN (`dir_up`←0).
  - Else (`dir_up`=0): the mirror image, with `below` checked first.
  - No requests → stay in IDLE.
- **MOVE_UP / MOVE_DOWN**
  - The travel timer is loaded with TRAVEL_CYCLES-1 on entry.
  - When the timer reaches 0, `floor` is incremented (MOVE_UP) or decremented (MOVE_DOWN).
  - Stop at the new floor if any of these holds:
    - a car call at that floor;
    - a hall call in the travel direction at that floor;
    - an opposite hall call at that floor with nothing beyond it;
    - the car is at the terminal floor.
  - On a stop: DOOR_OPEN if `req[floor]`, else IDLE. Otherwise the timer reloads and travel continues.
- **DOOR_OPEN**
  - On the entry cycle, the service direction is fixed:
    - keep `dir_up` if requests exist beyond `floor` in that direction;
    - else flip it if the opposite hall call is active;
    - else keep it.
  - Still on the entry cycle, pulse `inactivate_in_levels[floor]` and the hall-call clear that matches the service direction.
  - The door timer is loaded with DOOR_CYCLES-1. On expiry, re-evaluate exactly as in IDLE. A call re-latched at the same floor reopens the door.
- Requests cancelled while the car is moving (the button stage toggles them off) take effect at the next floor arrival. If nothing remains, the car stops there and goes to IDLE without opening the door.
- `floor` never leaves the range 0..FLOORS-1. Move commands beyond the terminal floors are impossible by construction.

## Timing
- Reset values: state IDLE, `floor`=0, `dir_up`=1, all `inactivate_*`=0, `motor_up`=`motor_down`=`door_open`=0, timers 0.
- All outputs are registered and reflect the current state. `motor_*` are high for every cycle of MOVE_*; `door_open` is high for every cycle of DOOR_OPEN.
- IDLE → DOOR_OPEN or MOVE_* takes one cycle after `req` is visible.
- Each floor transition takes exactly TRAVEL_CYCLES cycles. The door is open for exactly DOOR_CYCLES cycles.
- `inactivate_*` pulses are exactly one cycle wide, issued in the first DOOR_OPEN cycle. The button stage sees a rising edge on each pulse.
- Reset asserted mid-move or mid-door returns all state to the reset values on the next edge. The car position is re-homed to floor 0.

## Configuration
- `ELEVATOR_CTRL_DOOR_HOLD_EN`
  - Defined: adds input `door_hold` (1 bit). While it is high in DOOR_OPEN, the door timer reloads DOOR_CYCLES-1 every cycle, so the door closes DOOR_CYCLES cycles after `door_hold` falls.
  - Undefined: the port does not exist and the door time is fixed.

## Structure
- Package `elevator_pkg` holds:
  - the state enum `ctrl_state_t` {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN};
  - the direction constants `DIR_UP=1'b1`, `DIR_DOWN=1'b0`;
  - default values for FLOORS, TRAVEL_CYCLES and DOOR_CYCLES.
- Sub-module `elevator_timer`: a loadable down-counter with `load`, `load_val` and a `zero` flag. It is instantiated twice, once for travel and once for the door.

## Test plan
All scenarios use FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6.
1. Reset, then `active_in_levels`=8'h08 → MOVE_UP for 12 cycles; `floor`=3; DOOR_OPEN for 6 cycles; `inactivate_in_levels`=8'h08 for 1 cycle; then IDLE.
2. Car at floor 0, in-call at 5, up-call at 2 raised at cycle 2 → stop at floor 2 first with up-clear pulse bit 2, then continue to floor 5.
3. Car at floor 6 moving up, only down-call at 4 and in-call at 7 → serve 7, reverse, stop at 4; down-clear pulse bit 3 (index 4).
4. Car at floor 3, both up and down hall calls at 3, no other requests → door opens; only the hall call matching `dir_up` is cleared; the other reopens the door after 6 cycles.
5. In-call at 6 cancelled while passing floor 2 → car stops at floor 3, `door_open` stays 0, IDLE.
6. `reset` low for one cycle mid-move at floor 4 → next cycle `floor`=0, `motor_up`=0, state IDLE.
